// File: rtl/instruction_loader.sv
// instruction_loader: boot-time program loader.
// Receives a little-endian 16-bit word count followed by that many 32-bit
// little-endian words over a valid/ready byte stream, writes them to
// instruction memory from address 0, and holds the core in reset until the
// whole image has been written.
module instruction_loader #(
  parameter  int CAPACITY   = 512,
  parameter  int BUS_WIDTH  = 32,
  localparam int ADDR_WIDTH = $clog2(CAPACITY)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [BUS_WIDTH-1:0]  data_in,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    WORD,
    DONE,
    ERROR
  } state_t;

  // Capacity expressed in the width of the received word count.
  localparam logic [15:0] CAP_COUNT = 16'(CAPACITY);

  state_t                state, state_nxt;
  logic [7:0]            len_lo, len_lo_nxt;
  logic [15:0]           count, count_nxt;
  // One bit wider than an address so it can count past the last word
  // without the address itself ever wrapping.
  logic [ADDR_WIDTH:0]   word_cnt, word_cnt_nxt;
  logic [1:0]            byte_idx, byte_idx_nxt;
  // Holds bytes 0..2 of the word being assembled; byte 3 goes straight
  // into data_in together with these, so data_in is never disturbed by
  // bytes of the following word.
  logic [23:0]           asm_word, asm_word_nxt;
  logic                  final_write, final_write_nxt;

  logic                  byte_ready_nxt;
  logic [ADDR_WIDTH-1:0] write_addr_nxt;
  logic [BUS_WIDTH-1:0]  data_in_nxt;
  logic                  wr_en_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic                  error_nxt;
  logic                  cpu_hold_nxt;

  logic                  xfer;
  logic [15:0]           len_word;
  logic                  last_word;

  assign xfer      = byte_valid && byte_ready;
  assign len_word  = {byte_in, len_lo};
  assign last_word = (16'(word_cnt) == (count - 16'd1));

  // State, counters and all registered outputs; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_lo      <= '0;
      count       <= '0;
      word_cnt    <= '0;
      byte_idx    <= '0;
      asm_word    <= '0;
      final_write <= 1'b0;
      byte_ready  <= 1'b0;
      write_addr  <= '0;
      data_in     <= '0;
      wr_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cpu_hold    <= 1'b1;
    end else begin
      state       <= state_nxt;
      len_lo      <= len_lo_nxt;
      count       <= count_nxt;
      word_cnt    <= word_cnt_nxt;
      byte_idx    <= byte_idx_nxt;
      asm_word    <= asm_word_nxt;
      final_write <= final_write_nxt;
      byte_ready  <= byte_ready_nxt;
      write_addr  <= write_addr_nxt;
      data_in     <= data_in_nxt;
      wr_en       <= wr_en_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
      cpu_hold    <= cpu_hold_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless changed,
  // except wr_en which is a single-cycle pulse.
  always_comb begin
    state_nxt       = state;
    len_lo_nxt      = len_lo;
    count_nxt       = count;
    word_cnt_nxt    = word_cnt;
    byte_idx_nxt    = byte_idx;
    asm_word_nxt    = asm_word;
    final_write_nxt = final_write;
    byte_ready_nxt  = byte_ready;
    write_addr_nxt  = write_addr;
    data_in_nxt     = data_in;
    wr_en_nxt       = 1'b0;
    busy_nxt        = busy;
    done_nxt        = done;
    error_nxt       = error;
    cpu_hold_nxt    = cpu_hold;

    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_nxt       = LEN0;
          word_cnt_nxt    = '0;
          byte_idx_nxt    = '0;
          final_write_nxt = 1'b0;
          done_nxt        = 1'b0;
          error_nxt       = 1'b0;
          busy_nxt        = 1'b1;
          byte_ready_nxt  = 1'b1;
          cpu_hold_nxt    = 1'b1;
        end
      end

      LEN0: begin
        if (xfer) begin
          len_lo_nxt = byte_in;
          state_nxt  = LEN1;
        end
      end

      LEN1: begin
        if (xfer) begin
          count_nxt = len_word;
          if (len_word == 16'd0) begin
            state_nxt      = DONE;
            done_nxt       = 1'b1;
            busy_nxt       = 1'b0;
            byte_ready_nxt = 1'b0;
            cpu_hold_nxt   = 1'b0;
          end else if (len_word > CAP_COUNT) begin
            state_nxt      = ERROR;
            error_nxt      = 1'b1;
            busy_nxt       = 1'b0;
            byte_ready_nxt = 1'b0;
          end else begin
            state_nxt = WORD;
          end
        end
      end

      WORD: begin
        if (final_write) begin
          // The last word's write pulse is on the bus this cycle.
          state_nxt       = DONE;
          final_write_nxt = 1'b0;
          done_nxt        = 1'b1;
          busy_nxt        = 1'b0;
          cpu_hold_nxt    = 1'b0;
        end else if (xfer) begin
          case (byte_idx)
            2'd0: begin
              asm_word_nxt[7:0] = byte_in;
              byte_idx_nxt      = 2'd1;
            end
            2'd1: begin
              asm_word_nxt[15:8] = byte_in;
              byte_idx_nxt       = 2'd2;
            end
            2'd2: begin
              asm_word_nxt[23:16] = byte_in;
              byte_idx_nxt        = 2'd3;
            end
            default: begin
              data_in_nxt    = {byte_in, asm_word};
              write_addr_nxt = word_cnt[ADDR_WIDTH-1:0];
              wr_en_nxt      = 1'b1;
              word_cnt_nxt   = word_cnt + 1'b1;
              byte_idx_nxt   = 2'd0;
              if (last_word) begin
                final_write_nxt = 1'b1;
                byte_ready_nxt  = 1'b0;
              end
            end
          endcase
        end
      end

      default: begin
        state_nxt      = IDLE;
        busy_nxt       = 1'b0;
        byte_ready_nxt = 1'b0;
        cpu_hold_nxt   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed and randomized image loads checked
// against a byte-stream model of the loader.
module tb_instruction_loader;

  localparam int CAPACITY   = 512;
  localparam int ADDR_WIDTH = $clog2(CAPACITY);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [31:0]           data_in;
  logic                  wr_en;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  cpu_hold;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_rec_t;

  logic [7:0] img[$];
  int         xfer_cyc[$];
  wr_rec_t    wr_log[$];
  wr_rec_t    rec;
  int         done_cyc = -1;
  int         err_cyc  = -1;

  always #5 clk = ~clk;

  instruction_loader #(
    .CAPACITY (CAPACITY),
    .BUS_WIDTH(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .write_addr(write_addr),
    .data_in   (data_in),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpu_hold  (cpu_hold)
  );

  // Cycle counter used to timestamp transfers, writes and status changes.
  always @(posedge clk) cyc <= cyc + 1;

  // Observe the bus mid-cycle: byte transfers, write pulses, done/error rise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid && byte_ready) xfer_cyc.push_back(cyc);
      if (wr_en) begin
        rec.addr = int'(write_addr);
        rec.data = data_in;
        rec.cyc  = cyc;
        wr_log.push_back(rec);
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (error && err_cyc < 0) err_cyc = cyc;
    end
  end

  // Run-away guard.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    xfer_cyc.delete();
    wr_log.delete();
    done_cyc = -1;
    err_cyc  = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, byte_ready, 1'b0);
    check({tag, "_wr_en"},      wr_en,      1'b0);
    check({tag, "_write_addr"}, write_addr, '0);
    check({tag, "_data_in"},    data_in,    32'h0);
    check({tag, "_busy"},       busy,       1'b0);
    check({tag, "_done"},       done,       1'b0);
    check({tag, "_error"},      error,      1'b0);
    check({tag, "_cpu_hold"},   cpu_hold,   1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    clear_logs();
    check("start_busy",     busy,       1'b1);
    check("start_ready",    byte_ready, 1'b1);
    check("start_done",     done,       1'b0);
    check("start_error",    error,      1'b0);
    check("start_cpu_hold", cpu_hold,   1'b1);
  endtask

  // Offer one byte after a random idle gap and wait (bounded) for it to be taken.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int waited;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      @(posedge clk); #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    waited     = 0;
    @(negedge clk);
    while (!byte_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("byte_accepted", byte_ready, 1'b1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic build_random(input int n);
    img.delete();
    img.push_back(8'(n));
    img.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
  endtask

  // Start a load of img and compare what happened with the model's view:
  // count from bytes 0/1, word i assembled little-endian from bytes 2+4i..,
  // written to address i one cycle after its last byte, done one cycle later.
  task automatic run_load(input int max_gap);
    int          n;
    int          exp_bytes;
    int          exp_writes;
    int          base;
    logic [31:0] exp_word;
    n          = int'(img[0]) + 256 * int'(img[1]);
    exp_bytes  = (n > CAPACITY) ? 2 : 2 + 4 * n;
    exp_writes = (n > CAPACITY) ? 0 : n;
    pulse_start();
    for (int i = 0; i < exp_bytes; i++) send_byte(img[i], max_gap);
    byte_valid = 1'b1;
    byte_in    = 8'hA5;
    repeat (6) @(posedge clk);
    #1;
    byte_valid = 1'b0;

    check("xfer_count",  xfer_cyc.size(), exp_bytes);
    check("write_count", wr_log.size(),   exp_writes);
    for (int i = 0; i < exp_writes && i < wr_log.size(); i++) begin
      base     = 2 + 4 * i;
      exp_word = 32'(img[base]) + (32'(img[base + 1]) << 8) +
                 (32'(img[base + 2]) << 16) + (32'(img[base + 3]) << 24);
      check("write_addr", wr_log[i].addr, i);
      check("write_data", wr_log[i].data, exp_word);
      if (base + 3 < xfer_cyc.size())
        check("write_timing", wr_log[i].cyc, xfer_cyc[base + 3] + 1);
    end

    check("end_busy",       busy,       1'b0);
    check("end_byte_ready", byte_ready, 1'b0);
    if (n > CAPACITY) begin
      check("oversize_error",    error,    1'b1);
      check("oversize_done",     done,     1'b0);
      check("oversize_cpu_hold", cpu_hold, 1'b1);
      if (xfer_cyc.size() >= 2) check("error_timing", err_cyc, xfer_cyc[1] + 1);
    end else begin
      check("load_done",     done,     1'b1);
      check("load_error",    error,    1'b0);
      check("load_cpu_hold", cpu_hold, 1'b0);
      if (n == 0 && xfer_cyc.size() >= 2)
        check("done_timing_zero", done_cyc, xfer_cyc[1] + 1);
      else if (n > 0 && wr_log.size() == n)
        check("done_timing", done_cyc, wr_log[n - 1].cyc + 1);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;

    // Reset held for three cycles, then idle cycles without start.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("idle");

    // Back-to-back two-word image.
    img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(0);
    if (wr_log.size() == 2) begin
      check("b2b_word0", wr_log[0].data, 32'h12345678);
      check("b2b_word1", wr_log[1].data, 32'hDEADBEEF);
      check("b2b_spacing", wr_log[1].cyc - wr_log[0].cyc, 4);
    end

    // Same image with random gaps of up to five cycles.
    run_load(5);

    // Zero-length image.
    img = '{8'h00, 8'h00};
    run_load(0);

    // Full-capacity image, word i holds i.
    img.delete();
    img.push_back(8'h00);
    img.push_back(8'h02);
    for (int i = 0; i < CAPACITY; i++) begin
      img.push_back(8'(i));
      img.push_back(8'(i >> 8));
      img.push_back(8'h00);
      img.push_back(8'h00);
    end
    run_load(0);

    // Oversized count, then a valid random image must still load.
    img = '{8'h01, 8'h02};
    run_load(0);
    for (int r = 0; r < 3; r++) begin
      build_random(int'($urandom_range(6, 1)));
      run_load(int'($urandom_range(3, 0)));
    end

    // Reset asserted two bytes into the second word of a two-word image.
    build_random(2);
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(img[i], 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("reset_partial_not_written", wr_log.size(), 1);
    check_reset_outputs("after_reset");
    run_load(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
